// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot entry gate and slot manager.
// The gate controller imports the same defaults and status codes.
package parking_pkg;

    localparam int DEF_N_SLOTS = 8;
    localparam int DEF_SLOT_W  = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EVAL     = 3'd1,
        GRANT    = 3'd2,
        REJECT   = 3'd3,
        WAIT_LOW = 3'd4
    } state_t;

    // Codes the entry-gate controller reports on its status[1:0].
    localparam logic [1:0] STAT_IDLE   = 2'b00;
    localparam logic [1:0] STAT_GRANT  = 2'b01;
    localparam logic [1:0] STAT_REJECT = 2'b10;
    localparam logic [1:0] STAT_BUSY   = 2'b11;

endpackage

// File: rtl/slot_prio_enc.sv
// Combinational finder for the lowest-index free (zero) bit of the occupancy map.
module slot_prio_enc
    import parking_pkg::*;
#(
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int SLOT_W  = DEF_SLOT_W
) (
    input  logic [N_SLOTS-1:0] map,
    output logic [SLOT_W-1:0]  idx,
    output logic               any_free
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    // Scanning high-to-low lets the lowest free index overwrite the others.
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!map[i]) begin
                idx      = SLOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_slot_manager.sv
// Entry-gate responder: answers each req edge with a HOLD-cycle grant or reject,
// owns the slot occupancy map and releases slots on exit events.
module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int SLOT_W  = DEF_SLOT_W,
    parameter int HOLD    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              ex_sn,
    input  logic [SLOT_W-1:0] ex_slot,
    output logic              gL,
    output logic              rL,
    output logic [SLOT_W-1:0] slot_id,
    output logic [SLOT_W:0]   occ_cnt,
    output logic              full,
    output logic              err
);

    localparam int HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int OCC_W  = SLOT_W + 1;
    localparam logic [N_SLOTS-1:0] ONE_HOT0 = N_SLOTS'(1);

    state_t              r_state;
    logic                r_req_q;
    logic [HCNT_W-1:0]   r_hold;
    logic                r_gl;
    logic                r_rl;
    logic [SLOT_W-1:0]   r_slot_id;
    logic [N_SLOTS-1:0]  r_map;
    logic [OCC_W-1:0]    r_occ;
    logic                r_full;
    logic                r_err;

    logic [SLOT_W-1:0]   w_free_idx;
    logic                w_any_free;
    logic                w_alloc;
    logic                w_ex_hit;
    logic [N_SLOTS-1:0]  w_ex_mask;
    logic [N_SLOTS-1:0]  w_alloc_mask;
    logic [N_SLOTS-1:0]  w_map_nxt;
    logic [OCC_W-1:0]    w_occ_nxt;

    slot_prio_enc #(.N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W)) u_prio (
        .map      (r_map),
        .idx      (w_free_idx),
        .any_free (w_any_free)
    );

    // An out-of-range ex_slot shifts the one-hot bit off the top, so it never hits.
    assign w_ex_mask    = ONE_HOT0 << ex_slot;
    assign w_ex_hit     = ex_sn && |(r_map & w_ex_mask);
    assign w_alloc      = (r_state == EVAL) && w_any_free;
    assign w_alloc_mask = w_alloc ? (ONE_HOT0 << w_free_idx) : '0;
    assign w_map_nxt    = (r_map & ~(w_ex_hit ? w_ex_mask : '0)) | w_alloc_mask;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_alloc && !w_ex_hit)
            w_occ_nxt = r_occ + OCC_W'(1);
        else if (!w_alloc && w_ex_hit)
            w_occ_nxt = r_occ - OCC_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    // req_q resets high so a req already held during reset is not taken as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_req_q   <= 1'b1;
            r_hold    <= '0;
            r_gl      <= 1'b0;
            r_rl      <= 1'b0;
            r_slot_id <= '0;
        end else begin
            r_req_q <= req;
            case (r_state)
                IDLE: begin
                    if (req && !r_req_q)
                        r_state <= EVAL;
                end
                EVAL: begin
                    r_hold <= HCNT_W'(HOLD - 1);
                    if (w_any_free) begin
                        r_state   <= GRANT;
                        r_gl      <= 1'b1;
                        r_slot_id <= w_free_idx;
                    end else begin
                        r_state <= REJECT;
                        r_rl    <= 1'b1;
                    end
                end
                GRANT, REJECT: begin
                    if (r_hold == '0) begin
                        r_gl    <= 1'b0;
                        r_rl    <= 1'b0;
                        r_state <= WAIT_LOW;
                    end else begin
                        r_hold <= r_hold - HCNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (!req)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the occupancy map is a handful of flops, so it is reset; a reset mid-answer leaves nothing committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_map  <= '0;
            r_occ  <= '0;
            r_full <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_map  <= w_map_nxt;
            r_occ  <= w_occ_nxt;
            r_full <= (w_occ_nxt == OCC_W'(N_SLOTS));
            r_err  <= ex_sn && !w_ex_hit;
        end
    end

    assign gL      = r_gl;
    assign rL      = r_rl;
    assign slot_id = r_slot_id;
    assign occ_cnt = r_occ;
    assign full    = r_full;
    assign err     = r_err;

endmodule
